// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel registered multiplexer with valid/ready handshaking.
// Picks one requesting channel per cycle (round-robin or fixed priority) and
// loads its word into a one-entry output register that drains on out_ready.
module arb_mux_n #(
  parameter int unsigned width    = 16,
  parameter int unsigned channels = 4,
  parameter int unsigned rr_mode  = 1
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [channels-1:0]           in_valid,
  input  logic [channels*width-1:0]     in_data,
  output logic [channels-1:0]           in_ready,
  output logic                          out_valid,
  output logic [width-1:0]              out_data,
  output logic [$clog2(channels)-1:0]   out_ch,
  input  logic                          out_ready
);

  localparam int unsigned cw = $clog2(channels);
  localparam logic [cw-1:0] last_ch = cw'(channels - 1);

  logic [cw-1:0]    ptr_q;
  logic             out_valid_q;
  logic [width-1:0] out_data_q;
  logic [cw-1:0]    out_ch_q;

  logic [cw-1:0]    grant;
  logic             grant_found;
  logic [width-1:0] sel_data;
  logic             can_accept;
  logic             xfer;
  int unsigned      idx;

  // Arbitration: scan from ptr upward (round-robin) or from 0 (fixed priority).
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < channels; k++) begin
      if (rr_mode != 0) begin
        idx = (32'(ptr_q) + k) % channels;
      end else begin
        idx = k;
      end
      if (!grant_found && in_valid[idx[cw-1:0]]) begin
        grant_found = 1'b1;
        grant       = idx[cw-1:0];
      end
    end
  end

  // Data selection for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < channels; k++) begin
      if (grant == cw'(k)) begin
        sel_data = in_data[k*width +: width];
      end
    end
  end

  // Handshake: accept only into an empty or draining register, never in reset.
  always_comb begin
    can_accept = !out_valid_q || out_ready;
    xfer       = grant_found && can_accept && Reset_n;
    in_ready   = '0;
    if (xfer) begin
      in_ready = channels'(1) << grant;
    end
  end

  // Output register and round-robin pointer; ptr moves only on a transfer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_ch_q    <= grant;
        if (rr_mode != 0) begin
          ptr_q <= (grant == last_ch) ? '0 : grant + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
